// File: rtl/alu_seq_ctrl.sv
// Calculator operation sequencer: captures operands on IN_finish, validates, runs a start/done
// ALU transaction with timeout, holds the result until acknowledged. Optional macro: CALC_CHAIN_EN.
module alu_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned RES_W       = 32
) (
  input  logic             IN_clk,
  input  logic             IN_reset,
  input  logic             IN_finish,
  input  logic [7:0]       IN_SRCH,
  input  logic [7:0]       IN_SRCL,
  input  logic [7:0]       IN_DSTH,
  input  logic [7:0]       IN_DSTL,
  input  logic [3:0]       IN_ALU_OP,
`ifdef CALC_CHAIN_EN
  input  logic             IN_chain,
`endif
  output logic [15:0]      OUT_ALU_A,
  output logic [15:0]      OUT_ALU_B,
  output logic [3:0]       OUT_ALU_OP,
  output logic             OUT_ALU_start,
  input  logic             IN_ALU_done,
  input  logic [RES_W-1:0] IN_ALU_result,
  input  logic             IN_ALU_ovf,
  output logic [RES_W-1:0] OUT_RESULT,
  output logic [1:0]       OUT_error,
  output logic             OUT_valid,
  input  logic             IN_ack,
  output logic             OUT_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    E_OK      = 2'd0,
    E_BAD_OP  = 2'd1,
    E_OVF     = 2'd2,
    E_TIMEOUT = 2'd3
  } err_e;

  localparam logic [3:0]  OP_DIV  = 4'hD;
  // Expiry fires on the TIMEOUT_CYC-th WAIT cycle; the counter holds cycles already spent.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [RES_W-1:0]  res_q, res_d;
  err_e              err_q, err_d;
  logic [15:0]       a_src;
  logic              op_bad;

`ifdef CALC_CHAIN_EN
  logic [15:0]       last_q, last_d;
  assign a_src = IN_chain ? last_q : {IN_SRCH, IN_SRCL};
`else
  assign a_src = {IN_SRCH, IN_SRCL};
`endif

  assign op_bad = (op_q < 4'hA) || (op_q > OP_DIV) || ((op_q == OP_DIV) && (b_q == 16'd0));

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef CALC_CHAIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (IN_finish) begin
          a_d     = a_src;
          b_d     = {IN_DSTH, IN_DSTL};
          op_d    = IN_ALU_OP;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_bad) begin
          err_d   = E_BAD_OP;
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A done arriving on the expiry cycle still counts as a normal completion.
        if (IN_ALU_done) begin
          err_d   = IN_ALU_ovf ? E_OVF : E_OK;
          res_d   = IN_ALU_ovf ? '0 : IN_ALU_result;
          state_d = S_DONE;
`ifdef CALC_CHAIN_EN
          if (!IN_ALU_ovf) last_d = IN_ALU_result[15:0];
`endif
        end else if (cnt_q == CNT_LAST) begin
          err_d   = E_TIMEOUT;
          res_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (IN_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge IN_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!IN_reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= E_OK;
`ifdef CALC_CHAIN_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef CALC_CHAIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign OUT_ALU_A     = a_q;
  assign OUT_ALU_B     = b_q;
  assign OUT_ALU_OP    = op_q;
  assign OUT_ALU_start = (state_q == S_ISSUE);
  assign OUT_valid     = (state_q == S_DONE);
  assign OUT_busy      = (state_q != S_IDLE);
  assign OUT_RESULT    = res_q;
  assign OUT_error     = err_q;

endmodule
